// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the FFT front-end blocks.
//   - FFT_WIDTH / FFT_DEPTH : default sample component width and lanes per bundle
//   - cplx_t                : one complex sample {r, q} at the default width
//   - bitrev()              : reverses the low nbits bits of an index
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_WIDTH = 9;
    localparam int FFT_DEPTH = 16;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] r;
        logic signed [FFT_WIDTH-1:0] q;
    } cplx_t;

    // Bit i of idx moves to bit (nbits-1-i); bits above nbits are ignored.
    function automatic int bitrev(input int idx, input int nbits);
        int res;
        res = 0;
        for (int b = 0; b < nbits; b++) begin
            res[nbits-1-b] = idx[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_bundle_bank.sv
// -----------------------------------------------------------------------------
// fft_bundle_bank
//   One DEPTH-lane register bank holding a bundle of complex samples.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset (clears lanes)
//     clear               : zero every lane this cycle
//     wr_en, wr_lane      : write wr_R/wr_Q into lane wr_lane
//     fill_en, fill_from  : zero every lane whose *sample index* is >= fill_from
//     lane_R, lane_Q      : current lane contents
//   With BITREV=1 a lane holds the sample whose index is the bit-reverse of the
//   lane number, so the zero-fill range is decided on that sample index rather
//   than on the lane number itself.
// -----------------------------------------------------------------------------
module fft_bundle_bank
    import fft_pkg::*;
#(
    parameter int WIDTH  = FFT_WIDTH,
    parameter int DEPTH  = FFT_DEPTH,
    parameter bit BITREV = 1'b0,
    parameter int LW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [LW-1:0]           wr_lane,
    input  logic signed [WIDTH-1:0] wr_R,
    input  logic signed [WIDTH-1:0] wr_Q,
    input  logic                    fill_en,
    input  logic [LW-1:0]           fill_from,
    output logic signed [WIDTH-1:0] lane_R [DEPTH],
    output logic signed [WIDTH-1:0] lane_Q [DEPTH]
);

    // Sample index stored in a given lane (bit reversal is its own inverse).
    function automatic logic [LW-1:0] sample_of_lane(input int lane);
        if (BITREV) begin
            return LW'(bitrev(lane, LW));
        end
        return LW'(lane);
    endfunction

    // A write never targets a lane being zero-filled: the written sample's
    // index is always below fill_from when both happen together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                lane_R[j] <= '0;
                lane_Q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (wr_en && (wr_lane == LW'(j))) begin
                    lane_R[j] <= wr_R;
                    lane_Q[j] <= wr_Q;
                end else if (clear || (fill_en && (sample_of_lane(j) >= fill_from))) begin
                    lane_R[j] <= '0;
                    lane_Q[j] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/fft_bundle_packer.sv
// -----------------------------------------------------------------------------
// fft_bundle_packer
//   Serial-to-parallel packer: collects DEPTH complex samples into one lane
//   bundle for the parallel butterfly stages, ping-pong buffered over two banks.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid/in_ready     : input sample handshake
//     in_last               : final sample of a frame (early => zero-fill rest)
//     in_R, in_Q            : signed sample components
//     out_valid/out_ready   : bundle handshake
//     out_R, out_Q          : bundle lanes, straight from the read bank
//     err_misalign          : sticky, in_last seen at an index other than DEPTH-1
//   DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module fft_bundle_packer
    import fft_pkg::*;
#(
    parameter int WIDTH  = FFT_WIDTH,
    parameter int DEPTH  = FFT_DEPTH,
    parameter bit BITREV = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic signed [WIDTH-1:0] in_R,
    input  logic signed [WIDTH-1:0] in_Q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_R [DEPTH],
    output logic signed [WIDTH-1:0] out_Q [DEPTH],
    output logic                    err_misalign
);

    localparam int LW = $clog2(DEPTH);

    logic [1:0]    full_q;
    logic [1:0]    full_d;
    logic          wr_bank_q;
    logic          rd_bank_q;
    logic [LW-1:0] idx_q;
    logic          err_q;

    logic          in_fire;
    logic          out_fire;
    logic          complete;
    logic          early_last;
    logic [LW-1:0] wr_lane;
    logic [LW-1:0] fill_from;
    logic [1:0]    bank_wr;
    logic [1:0]    bank_clear;

    logic signed [WIDTH-1:0] b0_R [DEPTH];
    logic signed [WIDTH-1:0] b0_Q [DEPTH];
    logic signed [WIDTH-1:0] b1_R [DEPTH];
    logic signed [WIDTH-1:0] b1_Q [DEPTH];

    // Handshakes depend only on registered bank state, so in_ready has no
    // combinational path from out_ready.
    assign in_ready     = ~full_q[wr_bank_q];
    assign out_valid    = full_q[rd_bank_q];
    assign err_misalign = err_q;

    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign complete   = in_fire & (in_last | (idx_q == LW'(DEPTH-1)));
    assign early_last = in_fire & in_last & (idx_q != LW'(DEPTH-1));
    assign fill_from  = idx_q + LW'(1);

    // Lane addressing and per-bank strobes. A completing write and a drain
    // always hit different banks (one needs an empty bank, the other a full one).
    always_comb begin
        wr_lane = idx_q;
        if (BITREV) begin
            wr_lane = LW'(bitrev(int'(idx_q), LW));
        end
        bank_wr[0]    = in_fire & ~wr_bank_q;
        bank_wr[1]    = in_fire &  wr_bank_q;
        bank_clear[0] = out_fire & ~rd_bank_q;
        bank_clear[1] = out_fire &  rd_bank_q;
    end

    // Next full flags: completion sets the write bank, drain frees the read bank.
    always_comb begin
        full_d = full_q;
        if (complete) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (out_fire) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            full_q <= full_d;
            if (complete) begin
                wr_bank_q <= ~wr_bank_q;
                idx_q     <= '0;
            end else if (in_fire) begin
                idx_q <= idx_q + LW'(1);
            end
            if (out_fire) begin
                rd_bank_q <= ~rd_bank_q;
            end
            if (early_last) begin
                err_q <= 1'b1;
            end
        end
    end

    fft_bundle_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BITREV(BITREV),
        .LW    (LW)
    ) u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bank_clear[0]),
        .wr_en    (bank_wr[0]),
        .wr_lane  (wr_lane),
        .wr_R     (in_R),
        .wr_Q     (in_Q),
        .fill_en  (early_last & ~wr_bank_q),
        .fill_from(fill_from),
        .lane_R   (b0_R),
        .lane_Q   (b0_Q)
    );

    fft_bundle_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BITREV(BITREV),
        .LW    (LW)
    ) u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bank_clear[1]),
        .wr_en    (bank_wr[1]),
        .wr_lane  (wr_lane),
        .wr_R     (in_R),
        .wr_Q     (in_Q),
        .fill_en  (early_last & wr_bank_q),
        .fill_from(fill_from),
        .lane_R   (b1_R),
        .lane_Q   (b1_Q)
    );

    // Bundle lanes come straight from the read bank registers.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            out_R[i] = rd_bank_q ? b1_R[i] : b0_R[i];
            out_Q[i] = rd_bank_q ? b1_Q[i] : b0_Q[i];
        end
    end

endmodule

// File: tb/tb_fft_bundle_packer.sv
// -----------------------------------------------------------------------------
// tb_fft_bundle_packer
//   Drives a natural-order packer and a bit-reversed packer with directed
//   sample streams. Expected bundles are queued as samples are accepted and a
//   monitor per instance compares them whenever a bundle handshake occurs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_bundle_packer;
    import fft_pkg::*;

    localparam int W = 9;
    localparam int D = 16;

    typedef cplx_t [D-1:0] bundle_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // natural-order instance
    logic                in_valid, in_ready, in_last, out_valid, out_ready, err_misalign;
    logic signed [W-1:0] in_R, in_Q;
    logic signed [W-1:0] out_R [D];
    logic signed [W-1:0] out_Q [D];

    // bit-reversed instance
    logic                br_in_valid, br_in_ready, br_in_last, br_out_valid, br_out_ready, br_err;
    logic signed [W-1:0] br_in_R, br_in_Q;
    logic signed [W-1:0] br_out_R [D];
    logic signed [W-1:0] br_out_Q [D];

    fft_bundle_packer #(.WIDTH(W), .DEPTH(D), .BITREV(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_R(in_R), .in_Q(in_Q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_R(out_R), .out_Q(out_Q), .err_misalign(err_misalign)
    );

    fft_bundle_packer #(.WIDTH(W), .DEPTH(D), .BITREV(1'b1)) dut_br (
        .clk(clk), .rst_n(rst_n),
        .in_valid(br_in_valid), .in_ready(br_in_ready), .in_last(br_in_last),
        .in_R(br_in_R), .in_Q(br_in_Q),
        .out_valid(br_out_valid), .out_ready(br_out_ready),
        .out_R(br_out_R), .out_Q(br_out_Q), .err_misalign(br_err)
    );

    // lane -> sample index for 4-bit reversal, worked out by hand
    int brTable [D] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    int total = 0;
    int bad   = 0;
    int stalls = 0;
    int accNat = 0;

    bundle_t expNat[$];
    bundle_t expBr[$];
    bundle_t mNat;
    bundle_t mBr;
    int natIdx = 0;
    int brIdx  = 0;

    task automatic checkValue(input string name, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: record an accepted sample and queue completed bundles.
    task automatic modelAccept(input bit sel, input logic signed [W-1:0] r,
                               input logic signed [W-1:0] q, input logic last);
        if (!sel) begin
            accNat++;
            mNat[natIdx].r = r;
            mNat[natIdx].q = q;
            if (last || natIdx == D-1) begin
                for (int i = natIdx + 1; i < D; i++) mNat[i] = '0;
                expNat.push_back(mNat);
                natIdx = 0;
            end else begin
                natIdx++;
            end
        end else begin
            mBr[brTable[brIdx]].r = r;
            mBr[brTable[brIdx]].q = q;
            if (last || brIdx == D-1) begin
                for (int i = brIdx + 1; i < D; i++) mBr[brTable[i]] = '0;
                expBr.push_back(mBr);
                brIdx = 0;
            end else begin
                brIdx++;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic applyStimulus(input bit sel, input logic signed [W-1:0] r,
                                 input logic signed [W-1:0] q, input logic last);
        int guard;
        bit ok;
        guard = 0;
        ok = 1'b1;
        if (!sel) begin
            in_valid = 1'b1; in_R = r; in_Q = q; in_last = last;
        end else begin
            br_in_valid = 1'b1; br_in_R = r; br_in_Q = q; br_in_last = last;
        end
        while (!(sel ? br_in_ready : in_ready)) begin
            if (guard >= 500) begin
                total++;
                bad++;
                $display("[TB] FAIL input timeout: in_ready stayed %0d, required 1", 0);
                ok = 1'b0;
                break;
            end
            stalls++;
            guard++;
            @(negedge clk);
        end
        if (ok) modelAccept(sel, r, q, last);
        @(negedge clk);
        if (!sel) begin
            in_valid = 1'b0; in_last = 1'b0;
        end else begin
            br_in_valid = 1'b0; br_in_last = 1'b0;
        end
    endtask

    // Pop the expected bundle for one instance and compare every lane.
    task automatic checkOutput(input bit sel);
        bundle_t e;
        int badLane;
        logic signed [W-1:0] aR, aQ;
        total++;
        if ((sel ? expBr.size() : expNat.size()) == 0) begin
            bad++;
            $display("[TB] FAIL bundle%0d: got an unexpected bundle, required none", sel);
            return;
        end
        e = sel ? expBr.pop_front() : expNat.pop_front();
        badLane = -1;
        for (int i = 0; i < D; i++) begin
            aR = sel ? br_out_R[i] : out_R[i];
            aQ = sel ? br_out_Q[i] : out_Q[i];
            if (badLane < 0 && (aR !== e[i].r || aQ !== e[i].q)) badLane = i;
        end
        if (badLane >= 0) begin
            bad++;
            aR = sel ? br_out_R[badLane] : out_R[badLane];
            aQ = sel ? br_out_Q[badLane] : out_Q[badLane];
            $display("[TB] FAIL bundle%0d lane %0d: got R=%0d Q=%0d, expected R=%0d Q=%0d",
                     sel, badLane, aR, aQ, $signed(e[badLane].r), $signed(e[badLane].q));
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) checkOutput(1'b0);
    end

    always @(negedge clk) begin
        #1;
        if (rst_n && br_out_valid && br_out_ready) checkOutput(1'b1);
    end

    task automatic waitDrain(input string name);
        int c;
        c = 0;
        while ((expNat.size() != 0 || expBr.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
        end
        checkValue(name, expNat.size() + expBr.size(), 0);
    endtask

    // Called at a falling edge; asserts reset, flushes the model, releases.
    task automatic resetDut();
        rst_n = 1'b0;
        expNat.delete();
        expBr.delete();
        natIdx = 0;
        brIdx = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic checkLanesZero(input string name);
        int nz;
        nz = 0;
        for (int i = 0; i < D; i++) if (out_R[i] !== '0 || out_Q[i] !== '0) nz++;
        checkValue(name, nz, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_valid = 0; in_last = 0; in_R = 0; in_Q = 0; out_ready = 0;
        br_in_valid = 0; br_in_last = 0; br_in_R = 0; br_in_Q = 0; br_out_ready = 0;
        @(negedge clk);
        checkValue("reset in_ready", in_ready, 1);
        checkValue("reset out_valid", out_valid, 0);
        checkValue("reset err", err_misalign, 0);
        checkLanesZero("reset lanes zero");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: streaming natural order, in_last on the final (aligned) sample
        $display("[TB] test 1 streaming");
        out_ready = 1'b1;
        stalls = 0;
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b0, W'(k), W'(-k), k == 31);
            if (k == 14) checkValue("t1 valid before k15", out_valid, 0);
            if (k == 15) checkValue("t1 valid after k15", out_valid, 1);
            if (k == 30) checkValue("t1 valid before k31", out_valid, 0);
            if (k == 31) checkValue("t1 valid after k31", out_valid, 1);
        end
        checkValue("t1 in_ready stalls", stalls, 0);
        waitDrain("t1 drain");
        checkValue("t1 aligned last no err", err_misalign, 0);

        // 2: bit-reversed instance, bundle held so lanes can be inspected
        $display("[TB] test 2 bit reversed");
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, W'(k), W'(-k), 1'b0);
        checkValue("t2 valid", br_out_valid, 1);
        checkValue("t2 lane0", br_out_R[0], 0);
        checkValue("t2 lane1", br_out_R[1], 8);
        checkValue("t2 lane2", br_out_R[2], 4);
        checkValue("t2 lane8", br_out_R[8], 1);
        checkValue("t2 lane15", br_out_R[15], 15);
        br_out_ready = 1'b1;
        waitDrain("t2 drain");
        br_out_ready = 1'b0;

        // 3: backpressure with both banks full
        $display("[TB] test 3 backpressure");
        resetDut();
        out_ready = 1'b0;
        begin
            int base;
            base = accNat;
            fork
                begin
                    for (int k = 0; k < 40; k++) applyStimulus(1'b0, W'(k), W'(-k), 1'b0);
                end
                begin
                    int c;
                    c = 0;
                    @(negedge clk);
                    while (in_ready && c < 200) begin
                        @(negedge clk);
                        c++;
                    end
                    checkValue("t3 accepted before stall", accNat - base, 32);
                    checkValue("t3 in_ready low", in_ready, 0);
                    checkValue("t3 hold lane5 R", out_R[5], 5);
                    repeat (3) @(negedge clk);
                    checkValue("t3 still held lane5 R", out_R[5], 5);
                    checkValue("t3 still held lane5 Q", out_Q[5], -5);
                    checkValue("t3 still valid", out_valid, 1);
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                    checkValue("t3 bundle1 lane0", out_R[0], 16);
                    checkValue("t3 bundle1 valid", out_valid, 1);
                    checkValue("t3 in_ready freed", in_ready, 1);
                end
            join
        end
        for (int k = 40; k < 48; k++) applyStimulus(1'b0, W'(k), W'(-k), 1'b0);
        out_ready = 1'b1;
        waitDrain("t3 drain");

        // 4: early in_last zero-fills and sets the sticky error
        $display("[TB] test 4 early last");
        resetDut();
        out_ready = 1'b1;
        checkValue("t4 err before", err_misalign, 0);
        for (int v = 1; v <= 5; v++) applyStimulus(1'b0, W'(v), W'(-v), v == 5);
        checkValue("t4 err set", err_misalign, 1);
        checkValue("t4 valid", out_valid, 1);
        checkValue("t4 lane4", out_R[4], 5);
        checkValue("t4 lane5 zero", out_R[5], 0);
        checkValue("t4 lane15 zero", out_Q[15], 0);
        for (int v = 100; v < 116; v++) applyStimulus(1'b0, W'(v), W'(-v), 1'b0);
        waitDrain("t4 drain");
        checkValue("t4 err sticky", err_misalign, 1);

        // 5: reset mid-operation with one bundle pending and a partial frame
        $display("[TB] test 5 reset mid-op");
        out_ready = 1'b0;
        for (int k = 0; k < 23; k++) applyStimulus(1'b0, W'(k + 50), W'(-k), 1'b0);
        rst_n = 1'b0;
        #1;
        checkValue("t5 out_valid", out_valid, 0);
        checkValue("t5 in_ready", in_ready, 1);
        checkValue("t5 err cleared", err_misalign, 0);
        checkLanesZero("t5 lanes zero");
        expNat.delete();
        natIdx = 0;
        @(negedge clk);
        resetDut();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, W'(k + 7), W'(3 - k), 1'b0);
        waitDrain("t5 drain");

        // 6: drain of bank 0 on the same edge bank 1 completes
        $display("[TB] test 6 simultaneous");
        resetDut();
        out_ready = 1'b0;
        stalls = 0;
        for (int k = 0; k < 31; k++) applyStimulus(1'b0, W'(k), W'(-k), 1'b0);
        out_ready = 1'b1;
        applyStimulus(1'b0, W'(31), W'(-31), 1'b0);
        out_ready = 1'b0;
        checkValue("t6 bundle1 valid", out_valid, 1);
        checkValue("t6 bundle1 lane0", out_R[0], 16);
        checkValue("t6 in_ready", in_ready, 1);
        checkValue("t6 bundle0 consumed", expNat.size(), 1);
        for (int k = 32; k < 48; k++) applyStimulus(1'b0, W'(k), W'(-k), 1'b0);
        checkValue("t6 no stalls", stalls, 0);
        out_ready = 1'b1;
        waitDrain("t6 drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
